// File: rtl/mem_stage_if.sv
// Bundle of the EX->MEM inputs, the data-memory bus and the WB outputs of mem_stage.
// slave is the stage's view; master is the view of whoever drives EX and memory.
interface mem_stage_if;
  logic        in_valid;
  logic [31:0] alu_result_in;
  logic [31:0] store_data_in;
  logic [4:0]  rd_in;
  logic [2:0]  funct3_in;
  logic        MemREAD_in;
  logic        MemtoReg_in;
  logic        RegWrite_in;
  logic [1:0]  MemWrite_in;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        RegWrite_out;
  logic [4:0]  rd_out;
  logic [31:0] wb_data;
  logic        misalign_exc;

  modport slave (
    input  in_valid, alu_result_in, store_data_in, rd_in, funct3_in,
           MemREAD_in, MemtoReg_in, RegWrite_in, MemWrite_in,
           dmem_ready, dmem_rdata,
    output stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
           wb_valid, RegWrite_out, rd_out, wb_data, misalign_exc
  );

  modport master (
    output in_valid, alu_result_in, store_data_in, rd_in, funct3_in,
           MemREAD_in, MemtoReg_in, RegWrite_in, MemWrite_in,
           dmem_ready, dmem_rdata,
    input  stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
           wb_valid, RegWrite_out, rd_out, wb_data, misalign_exc
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues one registered data-memory request at a time and
// formats store lanes / load data. Define MISALIGN_TRAP_EN to trap misaligned accesses.
module mem_stage (
  input  logic       clk,
  input  logic       rst,
  mem_stage_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  state_t state_reg, state_next;

  logic        accept, is_store, is_mem, trap;
  logic [1:0]  size;
  logic [1:0]  addr_lo;
  logic [31:0] wdata_next;
  logic [3:0]  wstrb_next;
  logic [7:0]  rbyte [4];
  logic [15:0] rhalf;
  logic [31:0] load_data;

  logic        dmem_req_reg, dmem_we_reg;
  logic [31:0] dmem_addr_reg, dmem_wdata_reg;
  logic [3:0]  dmem_wstrb_reg;
  logic        wb_valid_reg, regwrite_reg;
  logic [4:0]  rd_reg;
  logic [31:0] wb_data_reg;

  // Context of the outstanding memory op, used when dmem_ready arrives
  logic [1:0]  lat_addr_lo_reg;
  logic [2:0]  lat_funct3_reg;
  logic        lat_load_reg, lat_memtoreg_reg, lat_regwrite_reg, lat_store_reg;
  logic [4:0]  lat_rd_reg;
  logic [31:0] lat_alu_reg;

  assign addr_lo  = bus.alu_result_in[1:0];
  assign is_store = (bus.MemWrite_in != 2'b00);
  assign is_mem   = bus.MemREAD_in | is_store;
  // Access size: 0 byte, 1 half, 2 word (stores use MemWrite, loads funct3)
  assign size     = is_store ? (bus.MemWrite_in - 2'd1) : bus.funct3_in[1:0];
  assign accept   = bus.in_valid && (state_reg == IDLE);
  assign bus.stall = (state_reg == BUSY);

`ifdef MISALIGN_TRAP_EN
  logic misalign_exc_reg;
  assign trap = is_mem && (((size == 2'd1) && addr_lo[0]) ||
                           ((size == 2'd2) && (addr_lo != 2'b00)));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_exc_reg <= 1'b0;
    else     misalign_exc_reg <= accept && trap;
  end
  assign bus.misalign_exc = misalign_exc_reg;
`else
  assign trap = 1'b0;
  assign bus.misalign_exc = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept && is_mem && !trap) state_next = BUSY;
      BUSY:    if (bus.dmem_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wdata_next = bus.store_data_in;
    wstrb_next = 4'b1111;
    case (size)
      2'd0: begin
        wdata_next = {4{bus.store_data_in[7:0]}};
        wstrb_next = 4'b0001 << addr_lo;
      end
      2'd1: begin
        wdata_next = {2{bus.store_data_in[15:0]}};
        wstrb_next = 4'b0011 << {addr_lo[1], 1'b0};
      end
      default: ;
    endcase
    if (!is_store) wstrb_next = 4'b0000;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rbyte[gi] = bus.dmem_rdata[8*gi +: 8];
  end

  assign rhalf = lat_addr_lo_reg[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];

  always_comb begin
    load_data = bus.dmem_rdata;
    case (lat_funct3_reg)
      3'b000:  load_data = {{24{rbyte[lat_addr_lo_reg][7]}}, rbyte[lat_addr_lo_reg]};
      3'b001:  load_data = {{16{rhalf[15]}}, rhalf};
      3'b100:  load_data = {24'd0, rbyte[lat_addr_lo_reg]};
      3'b101:  load_data = {16'd0, rhalf};
      default: load_data = bus.dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_req_reg     <= 1'b0;
      dmem_we_reg      <= 1'b0;
      dmem_addr_reg    <= 32'd0;
      dmem_wdata_reg   <= 32'd0;
      dmem_wstrb_reg   <= 4'd0;
      wb_valid_reg     <= 1'b0;
      regwrite_reg     <= 1'b0;
      rd_reg           <= 5'd0;
      wb_data_reg      <= 32'd0;
      lat_addr_lo_reg  <= 2'd0;
      lat_funct3_reg   <= 3'd0;
      lat_load_reg     <= 1'b0;
      lat_memtoreg_reg <= 1'b0;
      lat_regwrite_reg <= 1'b0;
      lat_store_reg    <= 1'b0;
      lat_rd_reg       <= 5'd0;
      lat_alu_reg      <= 32'd0;
    end else begin
      wb_valid_reg <= 1'b0;
      if (state_reg == IDLE) begin
        if (accept && !trap) begin
          if (is_mem) begin
            dmem_req_reg     <= 1'b1;
            dmem_we_reg      <= is_store;
            dmem_addr_reg    <= {bus.alu_result_in[31:2], 2'b00};
            dmem_wdata_reg   <= wdata_next;
            dmem_wstrb_reg   <= wstrb_next;
            lat_addr_lo_reg  <= addr_lo;
            lat_funct3_reg   <= bus.funct3_in;
            lat_load_reg     <= bus.MemREAD_in;
            lat_memtoreg_reg <= bus.MemtoReg_in;
            lat_regwrite_reg <= bus.RegWrite_in;
            lat_store_reg    <= is_store;
            lat_rd_reg       <= bus.rd_in;
            lat_alu_reg      <= bus.alu_result_in;
          end else begin
            wb_valid_reg <= 1'b1;
            wb_data_reg  <= bus.alu_result_in;
            rd_reg       <= bus.rd_in;
            regwrite_reg <= bus.RegWrite_in;
          end
        end
      end else if (bus.dmem_ready) begin
        dmem_req_reg <= 1'b0;
        dmem_we_reg  <= 1'b0;
        wb_valid_reg <= 1'b1;
        rd_reg       <= lat_rd_reg;
        regwrite_reg <= lat_regwrite_reg && !lat_store_reg;
        wb_data_reg  <= (lat_load_reg && lat_memtoreg_reg && !lat_store_reg) ? load_data
                                                                             : lat_alu_reg;
      end
    end
  end

  assign bus.dmem_req     = dmem_req_reg;
  assign bus.dmem_we      = dmem_we_reg;
  assign bus.dmem_addr    = dmem_addr_reg;
  assign bus.dmem_wdata   = dmem_wdata_reg;
  assign bus.dmem_wstrb   = dmem_wstrb_reg;
  assign bus.wb_valid     = wb_valid_reg;
  assign bus.RegWrite_out = regwrite_reg;
  assign bus.rd_out       = rd_reg;
  assign bus.wb_data      = wb_data_reg;
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: scoreboard of expected writebacks plus
// direct checks of the memory bus, stall timing and reset behaviour.
module tb_mem_stage;
  logic clk = 1'b0;
  logic rst;
  mem_stage_if bus();

  mem_stage dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        rw;
  } wb_t;
  wb_t sb[$];

  int checks = 0;
  int errors = 0;
  int ready_delay = 0;
  logic force_ready = 1'b0;
  logic [31:0] rdata_val = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end else
      $display("ok   %s = %h", tag, got);
  endtask

  // Memory responder: raises dmem_ready after ready_delay request cycles
  initial begin
    int wait_cnt = 0;
    bus.dmem_ready = 1'b0;
    bus.dmem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (rst || !bus.dmem_req) begin
        bus.dmem_ready = force_ready;
        wait_cnt = 0;
      end else if (wait_cnt >= ready_delay) begin
        bus.dmem_ready = 1'b1;
        bus.dmem_rdata = rdata_val;
      end else begin
        bus.dmem_ready = 1'b0;
        wait_cnt++;
      end
    end
  end

  // Writeback monitor: each wb_valid must match the oldest expected entry
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (bus.wb_valid === 1'b1) begin
        if (sb.size() == 0) check("wb_unexpected", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          check("wb_rd", 32'(bus.rd_out), 32'(e.rd));
          check("wb_data", bus.wb_data, e.data);
          check("wb_regwrite", 32'(bus.RegWrite_out), 32'(e.rw));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Drives one op once the stage is free; returns one cycle after acceptance
  task automatic send(input logic [31:0] alu, input logic [31:0] sdata, input logic [4:0] rd,
                      input logic [2:0] f3, input logic mr, input logic mtr, input logic rw,
                      input logic [1:0] mw, input logic [31:0] exp_data, input logic exp_rw,
                      input logic exp_wb);
    int n = 0;
    while (bus.stall && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (bus.stall) check("send_timeout", 32'd1, 32'd0);
    bus.alu_result_in = alu;
    bus.store_data_in = sdata;
    bus.rd_in         = rd;
    bus.funct3_in     = f3;
    bus.MemREAD_in    = mr;
    bus.MemtoReg_in   = mtr;
    bus.RegWrite_in   = rw;
    bus.MemWrite_in   = mw;
    bus.in_valid      = 1'b1;
    if (exp_wb) sb.push_back('{rd: rd, data: exp_data, rw: exp_rw});
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                      input logic [31:0] rdata, input logic [31:0] exp);
    rdata_val = rdata;
    send(addr, 32'd0, rd, f3, 1'b1, 1'b1, 1'b1, 2'b00, exp, 1'b1, 1'b1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.alu_result_in = 32'd0; bus.store_data_in = 32'd0;
    bus.rd_in = 5'd0; bus.funct3_in = 3'd0; bus.MemREAD_in = 1'b0;
    bus.MemtoReg_in = 1'b0; bus.RegWrite_in = 1'b0; bus.MemWrite_in = 2'b00;
    repeat (2) @(negedge clk);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_req", 32'(bus.dmem_req), 32'd0);
    check("rst_we_strb", 32'({bus.dmem_we, bus.dmem_wstrb}), 32'd0);
    check("rst_addr", bus.dmem_addr, 32'd0);
    check("rst_wdata", bus.dmem_wdata, 32'd0);
    check("rst_wb", 32'({bus.wb_valid, bus.RegWrite_out, bus.rd_out, bus.misalign_exc}), 32'd0);
    check("rst_wb_data", bus.wb_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // ALU op writes back one cycle after acceptance
    send(32'h0000_1234, 32'd0, 5'd5, 3'b000, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0000_1234, 1'b1, 1'b1);
    check("add_wb_valid", 32'(bus.wb_valid), 32'd1);
    check("add_req", 32'(bus.dmem_req), 32'd0);

    // SB at 0x103 with ready held low for three cycles
    ready_delay = 3;
    send(32'h0000_0103, 32'h0000_00AB, 5'd7, 3'b000, 1'b0, 1'b0, 1'b1, 2'b01,
         32'h0000_0103, 1'b0, 1'b1);
    check("sb_addr", bus.dmem_addr, 32'h0000_0100);
    check("sb_wdata", bus.dmem_wdata, 32'hABAB_ABAB);
    check("sb_wstrb", 32'(bus.dmem_wstrb), 32'h8);
    check("sb_we", 32'(bus.dmem_we), 32'd1);
    n = 0;
    while (bus.stall && n < 50) begin
      check("sb_hold", {bus.dmem_addr[31:4], bus.dmem_wstrb}, {28'h000_0010, 4'h8});
      n++;
      @(negedge clk);
    end
    check("sb_stall_cycles", n, 32'd4);
    ready_delay = 0;

    send(32'h0000_0102, 32'h1234_CDEF, 5'd8, 3'b001, 1'b0, 1'b0, 1'b0, 2'b10,
         32'h0000_0102, 1'b0, 1'b1);
    check("sh_wdata", bus.dmem_wdata, 32'hCDEF_CDEF);
    check("sh_wstrb", 32'(bus.dmem_wstrb), 32'hC);
    send(32'h0000_0104, 32'hCAFE_F00D, 5'd9, 3'b010, 1'b0, 1'b0, 1'b0, 2'b11,
         32'h0000_0104, 1'b0, 1'b1);
    check("sw_addr", bus.dmem_addr, 32'h0000_0104);
    check("sw_wdata", bus.dmem_wdata, 32'hCAFE_F00D);
    check("sw_wstrb", 32'(bus.dmem_wstrb), 32'hF);

    // Loads: sign/zero extension and minimum latency
    load(32'h0000_0202, 3'b000, 5'd1, 32'h0080_0000, 32'hFFFF_FF80);
    check("lb_addr", bus.dmem_addr, 32'h0000_0200);
    check("lb_we", 32'(bus.dmem_we), 32'd0);
    @(negedge clk);
    check("lb_latency", 32'(bus.wb_valid), 32'd1);
    load(32'h0000_0202, 3'b100, 5'd2, 32'h0080_0000, 32'h0000_0080);
    load(32'h0000_0202, 3'b001, 5'd3, 32'h8001_0000, 32'hFFFF_8001);
    load(32'h0000_0202, 3'b101, 5'd4, 32'h8001_0000, 32'h0000_8001);
    load(32'h0000_0200, 3'b010, 5'd6, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    load(32'h0000_0201, 3'b100, 5'd6, 32'h1122_3344, 32'h0000_0033);

    // Misaligned LH at 0x301
    n = 0;
    while (bus.stall && n < 20) begin @(negedge clk); n++; end
`ifdef MISALIGN_TRAP_EN
    rdata_val = 32'h0000_7F00;
    send(32'h0000_0301, 32'd0, 5'd14, 3'b001, 1'b1, 1'b1, 1'b1, 2'b00, 32'd0, 1'b0, 1'b0);
    check("mis_exc", 32'(bus.misalign_exc), 32'd1);
    check("mis_req", 32'(bus.dmem_req), 32'd0);
    check("mis_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    check("mis_exc_pulse", 32'(bus.misalign_exc), 32'd0);
`else
    load(32'h0000_0301, 3'b001, 5'd14, 32'h0000_7F00, 32'h0000_7F00);
    check("mis_addr", bus.dmem_addr, 32'h0000_0300);
    check("mis_exc", 32'(bus.misalign_exc), 32'd0);
`endif

    // dmem_ready in IDLE must not produce a writeback
    repeat (3) @(negedge clk);
    force_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ready_stall", 32'(bus.stall), 32'd0);
    check("idle_ready_wb", 32'(bus.wb_valid), 32'd0);
    force_ready = 1'b0;
    @(negedge clk);

    // Reset in the middle of a memory transaction
    ready_delay = 20;
    load(32'h0000_0400, 3'b010, 5'd10, 32'h1111_1111, 32'h1111_1111);
    @(negedge clk);
    check("mid_busy_stall", 32'(bus.stall), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_req", 32'(bus.dmem_req), 32'd0);
    check("async_rst_stall", 32'(bus.stall), 32'd0);
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    ready_delay = 0;
    send(32'h0000_0055, 32'd0, 5'd11, 3'b000, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0000_0055, 1'b1, 1'b1);
    load(32'h0000_0404, 3'b010, 5'd15, 32'h1234_5678, 32'h1234_5678);

    // Back-to-back LW then ADD, ready on first BUSY cycle
    load(32'h0000_0500, 3'b010, 5'd12, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    @(negedge clk);
    check("b2b_lw_wb", 32'(bus.wb_valid), 32'd1);
    check("b2b_stall", 32'(bus.stall), 32'd0);
    send(32'h0000_0077, 32'd0, 5'd13, 3'b000, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0000_0077, 1'b1, 1'b1);
    check("b2b_add_wb", 32'(bus.wb_valid), 32'd1);
    check("b2b_add_data", bus.wb_data, 32'h0000_0077);

    repeat (4) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, reset.
REQ-002 in_valid  input  1  EX result valid this cycle.
REQ-003 alu_result_in  input  32  ALU result; the byte address for loads and stores.
REQ-004 store_data_in  input  32  rs2 data for stores.
REQ-005 rd_in  input  5  destination register.
REQ-006 funct3_in  input  3  load size and sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-007 MemREAD_in, MemtoReg_in, RegWrite_in  input  1 each  control bits from EX.
REQ-008 MemWrite_in  input  2  store encoding: 00 none, 01 SB, 10 SH, 11 SW.
REQ-009 stall  output  1  upstream SHALL hold its outputs while this is high.
REQ-010 dmem_req  output  1  memory request; dmem_we  output  1  write enable.
REQ-011 dmem_addr  output  32  word address, bits [1:0] always 0.
REQ-012 dmem_wdata  output  32  store data; dmem_wstrb  output  4  byte-lane enables.
REQ-013 dmem_ready  input  1  completion strobe; dmem_rdata  input  32  valid when dmem_ready=1.
REQ-014 wb_valid, RegWrite_out  output  1  WB stage valid and register-write enable.
REQ-015 rd_out  output  5; wb_data  output  32  destination register and writeback value.
REQ-016 misalign_exc  output  1  one-cycle misaligned-access pulse.

Function
REQ-017 The stage SHALL accept an input when in_valid=1 and stall=0; a memory op is MemREAD_in=1 or MemWrite_in!=00.
REQ-018 FSM states SHALL be IDLE and BUSY; IDLE -> BUSY on accepting a memory op; BUSY -> IDLE on the cycle with dmem_ready=1.
REQ-019 stall SHALL equal (state==BUSY), combinationally.
REQ-020 A non-memory op SHALL produce wb_valid=1 with wb_data=alu_result_in exactly 1 cycle after acceptance.
REQ-021 For a memory op, dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_wstrb SHALL be registered, and SHALL stay asserted and stable from the cycle after acceptance until dmem_ready.
REQ-022 On dmem_ready in BUSY: wb_valid SHALL be 1 in the next cycle, with wb_data=extracted load data (or alu_result for stores) and RegWrite_out=0 for stores.
REQ-023 Minimum load latency SHALL be acceptance to wb_valid = 2 cycles.
REQ-024 Store lanes SHALL be: SB wdata={4{byte}}, wstrb=0001<<addr[1:0]; SH wdata={2{half}}, wstrb=0011<<{addr[1],0}; SW wstrb=1111.
REQ-025 Load extraction SHALL use the latched addr[1:0] and funct3: LB/LH sign-extend; LBU/LHU zero-extend; LW passes the whole word.
REQ-026 A misaligned access is a half access with addr[0]=1, or a word access with addr[1:0]!=00.
REQ-027 wb_valid SHALL be 0 in every cycle that no op completes; rd_out and RegWrite_out are don't-care while wb_valid=0.
REQ-028 dmem_ready while in IDLE SHALL be ignored.

Reset
REQ-029 rst SHALL asynchronously force state=IDLE and drive every output (stall, dmem_*, wb_valid, RegWrite_out, rd_out, wb_data, misalign_exc) to 0.
REQ-030 Reset while BUSY SHALL abandon the transaction: dmem_req drops immediately and no writeback occurs.

Configuration
REQ-031 With MISALIGN_TRAP_EN defined, a misaligned op SHALL issue no dmem_req, SHALL pulse misalign_exc=1 for 1 cycle after acceptance, SHALL keep wb_valid=0, and the FSM SHALL stay IDLE.
REQ-032 Without MISALIGN_TRAP_EN, misalign_exc SHALL be tied 0 and misaligned ops SHALL proceed at the aligned word address using the REQ-024/REQ-025 lane rules.

Verification
REQ-033 ADD with alu_result=0x00001234, rd=5 -> next cycle wb_valid=1, wb_data=0x00001234, rd_out=5, dmem_req=0.
REQ-034 SB with addr=0x103, data=0xAB, dmem_ready held low 3 cycles -> dmem_addr=0x100, wdata=0xABABABAB, wstrb=1000; stall=1 for 4 cycles; RegWrite_out=0.
REQ-035 LB with addr=0x202 and dmem_rdata=0x00800000 -> wb_data=0xFFFFFF80; the same access as LBU -> wb_data=0x00000080.
REQ-036 LH with addr=0x301: with MISALIGN_TRAP_EN -> misalign_exc=1 for one cycle, no dmem_req, wb_valid=0; without the macro -> a request issues at 0x300.
REQ-037 rst asserted mid-BUSY -> dmem_req=0 and stall=0 asynchronously; the first op accepted after release completes normally.
REQ-038 Back-to-back LW, ADD with ready on the first BUSY cycle -> ADD accepted the cycle after the LW's ready, and the two writebacks appear in order without overlap.
